fetch_stage: RTL

//  Instruction fetch front end feeding the Core decode stage.
//  - Owns the PC and issues one word request per cycle to a synchronous instruction memory.
//  - Buffers returned words with their PCs and hands {pc, instr} to decode over a valid/ready handshake.
//  - Redirects to a new PC on a taken branch/jump from the execute stage; misaligned targets stop fetch.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types: word width, FIFO entry layout and fetch FSM states.
package core_pkg;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAULT
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-2 FIFO of {pc, instr} entries; flush beats a same-cycle push.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, FSM, credit-limited issue and epoch-tagged response capture.
// Optional FETCH_STATS_EN adds fetched/flushed counters.
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_o,
   output logic [XLEN-1:0]   imem_addr_o,
   input  logic [XLEN-1:0]   imem_rdata_i,
   input  logic              redirect_valid_i,
   input  logic [XLEN-1:0]   redirect_pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   out_pc_o,
   output logic [XLEN-1:0]   out_instr_o,
   output logic              fault_o,
   output logic [XLEN-1:0]   fault_pc_o
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       fetched_cnt_o,
   output logic [31:0]       flushed_cnt_o
`endif
);

   localparam int unsigned CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_e     state;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  inflight_pc;
   logic [XLEN-1:0]  fault_pc;
   logic             inflight;
   logic             inflight_epoch;
   logic             epoch;
   logic [CW-1:0]    count;
   logic [CW:0]      credit_used;
   fetch_entry_t     head;
   fetch_entry_t     wdata;
   logic             redirect;
   logic             misaligned;
   logic             pop;
   logic             push;
   logic             issue;

   assign redirect    = redirect_valid_i && (state != IDLE);
   assign misaligned  = redirect_pc_i[1:0] != 2'b00;
   assign out_valid_o = (state == RUN) && (count != '0);
   assign pop         = out_valid_o && out_ready_i;

   // Credit counts FIFO entries plus the in-flight word; a same-cycle pop frees a slot.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue       = (state == RUN) && !redirect_valid_i && (credit_used < DEPTH_W);

   // Responses from an older epoch belong to a flushed stream and are dropped.
   assign push        = inflight && (inflight_epoch == epoch);
   assign wdata       = '{pc: inflight_pc, instr: imem_rdata_i};

   assign imem_req_o  = issue;
   assign imem_addr_o = issue ? pc : '0;
   assign out_pc_o    = out_valid_o ? head.pc : '0;
   assign out_instr_o = out_valid_o ? head.instr : '0;
   assign fault_o     = (state == FAULT);
   assign fault_pc_o  = fault_pc;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (wdata),
      .rdata (head),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         inflight_epoch <= 1'b0;
         epoch          <= 1'b0;
         fault_pc       <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc    <= pc;
            inflight_epoch <= epoch;
            pc             <= pc + XLEN'(4);
         end
         case (state)
            IDLE: state <= RUN;
            RUN, FAULT: begin
               if (redirect_valid_i) begin
                  epoch <= ~epoch;
                  if (misaligned) begin
                     state    <= FAULT;
                     fault_pc <= redirect_pc_i;
                  end else begin
                     state <= RUN;
                     pc    <= redirect_pc_i;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_cnt_o <= '0;
         flushed_cnt_o <= '0;
      end else begin
         if (pop) begin
            fetched_cnt_o <= fetched_cnt_o + 32'd1;
         end
         if (redirect) begin
            flushed_cnt_o <= flushed_cnt_o + 32'(count) - 32'(pop) + 32'(inflight);
         end
      end
   end
`endif

endmodule
